// File: rtl/cnn_pkg.sv
// Shared CNN datapath types and helpers: signed sample type, signed max, ReLU.
// Latency: n/a (combinational helpers only).
// Backpressure: n/a.
package cnn_pkg;

    localparam int DATA_W = 8;

    typedef logic signed [DATA_W-1:0] sample_t;

    // Signed maximum; on a tie either operand is the same value.
    function automatic sample_t smax(sample_t a, sample_t b);
        return (a > b) ? a : b;
    endfunction

    // Clamp negative samples to zero.
    function automatic sample_t relu(sample_t a);
        return a[DATA_W-1] ? sample_t'(0) : a;
    endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// Half-width row store for horizontal maxima; one write port, one combinational read port.
// Latency: write lands on the rising edge, read is same-cycle combinational.
// Backpressure: none, every write is accepted.
// Ports: clk; we/waddr/wdata write port; raddr/rdata read port.
module pool_line_buffer #(
    parameter int DEPTH = 12,
    parameter int WIDTH = 8,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    // Contents are never reset: every entry is rewritten on an even row
    // before the following odd row reads it.
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/conv_maxpool2x2.sv
// Optional ReLU then 2x2 stride-2 max-pool over a raster-order conv stream, on the fly.
// Latency: pooled result appears 1 cycle after the beat that completes its window.
// Backpressure: none; every in_valid beat is consumed, in_valid may have arbitrary gaps.
// Ports: clk, reset (sync, active-high); in_valid/in_data/relu_en input beat;
//        out_valid/out_data/out_col/out_row pooled sample; frame_done on last pooled sample.
module conv_maxpool2x2
    import cnn_pkg::*;
#(
    parameter int IMG_W  = 24,
    parameter int IMG_H  = 24,
    parameter int DATA_W = cnn_pkg::DATA_W,
    localparam int XW    = (IMG_W > 2) ? $clog2(IMG_W) : 1,
    localparam int YW    = (IMG_H > 2) ? $clog2(IMG_H) : 1,
    localparam int CW    = (IMG_W > 2) ? $clog2(IMG_W / 2) : 1,
    localparam int RW    = (IMG_H > 2) ? $clog2(IMG_H / 2) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              relu_en,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [CW-1:0]     out_col,
    output logic [RW-1:0]     out_row,
    output logic              frame_done
);

    if ((IMG_W % 2) != 0 || IMG_W < 2 || (IMG_H % 2) != 0 || IMG_H < 2) begin : g_bad_dims
        $fatal(1, "conv_maxpool2x2: IMG_W and IMG_H must be even and >= 2");
    end
    if (DATA_W != cnn_pkg::DATA_W) begin : g_bad_width
        $fatal(1, "conv_maxpool2x2: DATA_W must match cnn_pkg::DATA_W");
    end

    logic [XW-1:0] col_q, col_d;
    logic [YW-1:0] row_q, row_d;
    sample_t       h_q, h_d;            // even-column sample awaiting its odd partner
    logic          out_valid_q, out_valid_d;
    sample_t       out_data_q, out_data_d;
    logic [CW-1:0] out_col_q, out_col_d;
    logic [RW-1:0] out_row_q, out_row_d;
    logic          frame_done_q, frame_done_d;

    sample_t       x;
    sample_t       hm;
    sample_t       lb_rdata;
    logic [CW-1:0] lb_addr;
    logic          lb_we;
    logic          col_last;
    logic          row_last;

    assign x        = relu_en ? relu(sample_t'(in_data)) : sample_t'(in_data);
    assign hm       = smax(h_q, x);
    assign lb_addr  = CW'(col_q >> 1);
    assign col_last = (col_q == XW'(IMG_W - 1));
    assign row_last = (row_q == YW'(IMG_H - 1));
    // Even rows only write and odd rows only read, so the same address never
    // sees a read and a write in one cycle.
    assign lb_we    = in_valid && col_q[0] && !row_q[0];

    pool_line_buffer #(
        .DEPTH (IMG_W / 2),
        .WIDTH (DATA_W)
    ) u_line_buffer (
        .clk   (clk),
        .we    (lb_we),
        .waddr (lb_addr),
        .wdata (hm),
        .raddr (lb_addr),
        .rdata (lb_rdata)
    );

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        h_d          = h_q;
        out_valid_d  = 1'b0;
        out_data_d   = out_data_q;
        out_col_d    = out_col_q;
        out_row_d    = out_row_q;
        frame_done_d = 1'b0;

        if (in_valid) begin
            if (!col_q[0]) begin
                h_d = x;
            end else if (row_q[0]) begin
                out_valid_d  = 1'b1;
                out_data_d   = smax(lb_rdata, hm);
                out_col_d    = lb_addr;
                out_row_d    = RW'(row_q >> 1);
                frame_done_d = col_last && row_last;
            end

            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q        <= '0;
            row_q        <= '0;
            h_q          <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_col_q    <= '0;
            out_row_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            h_q          <= h_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_col_q    <= out_col_d;
            out_row_q    <= out_row_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_col    = out_col_q;
    assign out_row    = out_row_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_maxpool2x2.sv
// Bench for conv_maxpool2x2: a 4x4 instance and a 24x24 instance, scoreboard checked.
// Latency: expected outputs carry the exact cycle they must appear on.
// Backpressure: none in the design; stimulus may insert idle gaps.
module tb_conv_maxpool2x2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // 4x4 instance
    logic       s_vld, s_relu;
    logic [7:0] s_dat;
    logic       so_vld, so_fd;
    logic [7:0] so_dat;
    logic [0:0] so_col, so_row;

    // 24x24 instance
    logic       b_vld, b_relu;
    logic [7:0] b_dat;
    logic       bo_vld, bo_fd;
    logic [7:0] bo_dat;
    logic [3:0] bo_col, bo_row;

    conv_maxpool2x2 #(.IMG_W(4), .IMG_H(4), .DATA_W(8)) u_small (
        .clk(clk), .reset(reset), .in_valid(s_vld), .in_data(s_dat), .relu_en(s_relu),
        .out_valid(so_vld), .out_data(so_dat), .out_col(so_col), .out_row(so_row),
        .frame_done(so_fd)
    );

    conv_maxpool2x2 #(.IMG_W(24), .IMG_H(24), .DATA_W(8)) u_big (
        .clk(clk), .reset(reset), .in_valid(b_vld), .in_data(b_dat), .relu_en(b_relu),
        .out_valid(bo_vld), .out_data(bo_dat), .out_col(bo_col), .out_row(bo_row),
        .frame_done(bo_fd)
    );

    typedef struct {
        int d;
        int col;
        int row;
        bit fd;
        int cyc;
    } exp_t;

    exp_t qs[$];
    exp_t qb[$];

    int n_vec  = 0;
    int n_miss = 0;
    int n_out_big = 0;
    int n_fd_big  = 0;

    int frame[576];

    // ---------------- reference model helpers ----------------
    function automatic int pre(int v, bit r);
        return (r && v < 0) ? 0 : v;
    endfunction

    function automatic int max4(int a, int b, int c, int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    task automatic check_out(input bit big, input logic vld, input logic [7:0] dat,
                             input int col, input int row, input logic fd);
        exp_t e;
        if (!vld) begin
            if (fd) begin
                n_miss++;
                $display("FAIL %s frame_done_without_valid at cycle %0d", big ? "big" : "small", cyc);
            end
            return;
        end
        n_vec++;
        if (big) begin
            n_out_big++;
            if (fd) n_fd_big++;
        end
        if ((big && qb.size() == 0) || (!big && qs.size() == 0)) begin
            n_miss++;
            $display("FAIL %s unexpected_output cycle=%0d data=%0d col=%0d row=%0d fd=%0b required=none",
                     big ? "big" : "small", cyc, $signed(dat), col, row, fd);
            return;
        end
        e = big ? qb.pop_front() : qs.pop_front();
        if ($signed(dat) != e.d || col != e.col || row != e.row || fd != e.fd || cyc != e.cyc) begin
            n_miss++;
            $display("FAIL %s pooled_output actual data=%0d col=%0d row=%0d fd=%0b cycle=%0d required data=%0d col=%0d row=%0d fd=%0b cycle=%0d",
                     big ? "big" : "small", $signed(dat), col, row, fd, cyc,
                     e.d, e.col, e.row, e.fd, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        check_out(1'b0, so_vld, so_dat, int'(so_col), int'(so_row), so_fd);
        check_out(1'b1, bo_vld, bo_dat, int'(bo_col), int'(bo_row), bo_fd);
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit big, input logic v, input int d, input bit r);
        if (big) begin
            b_vld = v; b_dat = 8'(d); b_relu = r;
        end else begin
            s_vld = v; s_dat = 8'(d); s_relu = r;
        end
    endtask

    task automatic idle(input bit big, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk); #1;
            drive(big, 1'b0, 0, 1'b0);
        end
    endtask

    // Sends the first nbeats pixels of frame[] and records each completed
    // window's max (computed straight from the pixel grid) with its due cycle.
    task automatic run_frame(input bit big, input bit r, input bit gaps, input int nbeats);
        int w;
        int h;
        exp_t e;
        w = big ? 24 : 4;
        h = big ? 24 : 4;
        for (int i = 0; i < nbeats; i++) begin
            int pr;
            int pc;
            pr = i / w;
            pc = i % w;
            if (gaps) begin
                while ($urandom_range(0, 1) == 1) idle(big, 1);
            end
            @(negedge clk); #1;
            drive(big, 1'b1, frame[i], r);
            if ((pr % 2) == 1 && (pc % 2) == 1) begin
                e.d   = max4(pre(frame[(pr-1)*w + pc-1], r), pre(frame[(pr-1)*w + pc], r),
                             pre(frame[pr*w + pc-1], r),     pre(frame[pr*w + pc], r));
                e.col = pc / 2;
                e.row = pr / 2;
                e.fd  = (pr == h - 1) && (pc == w - 1);
                e.cyc = cyc + 1;
                if (big) qb.push_back(e); else qs.push_back(e);
            end
        end
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < 16; i++) frame[i] = i;
    endtask

    task automatic fill_const(input int v, input int n);
        for (int i = 0; i < n; i++) frame[i] = v;
    endtask

    task automatic fill_rand(input int n);
        for (int i = 0; i < n; i++) frame[i] = int'($signed(8'($urandom)));
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 0, 1'b0);
        drive(1'b1, 1'b0, 0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        reset = 1'b0;

        // Reset state of both instances.
        n_vec++;
        if (so_vld !== 1'b0 || so_dat !== 8'd0 || so_col !== 1'b0 || so_row !== 1'b0 || so_fd !== 1'b0 ||
            bo_vld !== 1'b0 || bo_dat !== 8'd0 || bo_col !== 4'd0 || bo_row !== 4'd0 || bo_fd !== 1'b0) begin
            n_miss++;
            $display("FAIL reset_state small=%b/%0d/%0d/%0d/%b big=%b/%0d/%0d/%0d/%b required all zero",
                     so_vld, so_dat, so_col, so_row, so_fd, bo_vld, bo_dat, bo_col, bo_row, bo_fd);
        end

        // Ramp 0..15 -> 5,7,13,15.
        fill_ramp();
        run_frame(1'b0, 1'b0, 1'b0, 16);
        idle(1'b0, 3);

        // All -128 with and without ReLU.
        fill_const(-128, 16);
        run_frame(1'b0, 1'b1, 1'b0, 16);
        idle(1'b0, 2);
        run_frame(1'b0, 1'b0, 1'b0, 16);
        idle(1'b0, 2);

        // Extreme window {-3,127|-128,4} at (0,0); all-negative window at (1,1).
        fill_rand(16);
        frame[0] = -3;  frame[1] = 127; frame[4] = -128; frame[5] = 4;
        frame[10] = -5; frame[11] = -2; frame[14] = -9;  frame[15] = -7;
        run_frame(1'b0, 1'b0, 1'b0, 16);
        idle(1'b0, 1);
        run_frame(1'b0, 1'b1, 1'b0, 16);
        idle(1'b0, 2);

        // Reset after 10 beats, then a clean ramp frame.
        fill_ramp();
        run_frame(1'b0, 1'b0, 1'b0, 10);
        @(negedge clk); #1;
        drive(1'b0, 1'b0, 0, 1'b0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        reset = 1'b0;
        run_frame(1'b0, 1'b0, 1'b0, 16);
        idle(1'b0, 2);

        // Two back-to-back random frames, no gap.
        fill_rand(16);
        run_frame(1'b0, 1'b0, 1'b0, 16);
        fill_rand(16);
        run_frame(1'b0, $urandom_range(0, 1) == 1, 1'b0, 16);
        idle(1'b0, 3);

        // Full 24x24 random frame with ~50% duty gaps.
        fill_rand(576);
        run_frame(1'b1, 1'b0, 1'b1, 576);
        idle(1'b1, 4);

        n_vec++;
        if (qs.size() != 0 || qb.size() != 0) begin
            n_miss++;
            $display("FAIL outstanding_expected small=%0d big=%0d required 0 and 0", qs.size(), qb.size());
        end
        n_vec++;
        if (n_out_big != 144 || n_fd_big != 1) begin
            n_miss++;
            $display("FAIL big_frame_counts out_valid=%0d frame_done=%0d required 144 and 1", n_out_big, n_fd_big);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
